mips_run_ctrl: RTL and testbench

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

---
 rtl/mips_ctrl_pkg.sv | 24 ++
 rtl/mips_run_monitor.sv | 62 ++++++
 rtl/mips_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS run controller.
//   run_state_e : controller FSM states
//   Def*        : default values for the controller parameters
//   sat16       : clamp a 32-bit count into a 16-bit status field
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StRun,
    StDump,
    StDone
  } run_state_e;

  localparam int unsigned DefResetCycles = 10;
  localparam int unsigned DefNopTimeout  = 9;
  localparam int unsigned DefWatchdog    = 500;
  localparam int unsigned DefDumpWords   = 22;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/mips_run_monitor.sv
// Run monitor: counts RUN cycles (watchdog) and consecutive zero instructions (nop run).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero both counters
//   en       : one RUN cycle elapses this clock
//   inst     : instruction word fetched this cycle
//   stop     : the update made this cycle reaches the nop or watchdog limit
//   wd_hit   : watchdog limit reached without the nop limit in the same cycle
//   count    : watch count including this cycle's update
module mips_run_monitor
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned NOP_TIMEOUT = DefNopTimeout,
  parameter int unsigned WATCHDOG    = DefWatchdog
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] inst,
  output logic        stop,
  output logic        wd_hit,
  output logic [31:0] count
);

  logic [31:0] nop_q, nop_d;
  logic [31:0] watch_q, watch_d;
  logic        nop_cond, wd_cond;

  always_comb begin
    nop_d   = nop_q;
    watch_d = watch_q;
    if (clr) begin
      nop_d   = '0;
      watch_d = '0;
    end else if (en) begin
      watch_d = (watch_q == 32'hFFFF_FFFF) ? watch_q : watch_q + 32'd1;
      nop_d   = (inst == 32'd0) ? nop_q + 32'd1 : 32'd0;
    end
  end

  // Limits are judged on the updated values so the exit happens in the limiting cycle.
  always_comb begin
    nop_cond = en && !clr && (nop_d == NOP_TIMEOUT);
    wd_cond  = en && !clr && (watch_d == WATCHDOG);
    stop     = nop_cond || wd_cond;
    // A simultaneous nop exit counts as a normal finish, not a watchdog expiry.
    wd_hit   = wd_cond && !nop_cond;
    count    = watch_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nop_q   <= '0;
      watch_q <= '0;
    end else begin
      nop_q   <= nop_d;
      watch_q <= watch_d;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// MIPS run controller: holds the core in reset, lets it run until it idles on zero
// instructions or the watchdog fires, then streams the first data-memory words out.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : single-cycle run request (honoured in IDLE/DONE only)
//   inst                     : instruction word fetched by the core
//   core_data_*              : core data-memory request / returned read data
//   core_rst_n               : active-low core reset, high only while running
//   mem_*                    : the single data-memory port (mem_rdata combinational)
//   dump_valid/ready/data/idx: result stream, valid/ready handshake
//   busy, done, wd_expired, run_cycles : status
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DefResetCycles,
  parameter int unsigned NOP_TIMEOUT  = DefNopTimeout,
  parameter int unsigned WATCHDOG     = DefWatchdog,
  parameter int unsigned DUMP_WORDS   = DefDumpWords
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] inst,
  input  logic [31:0] core_data_addr,
  input  logic        core_data_wr,
  input  logic [31:0] core_data_in,
  output logic [31:0] core_data_out,
  output logic        core_rst_n,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [4:0]  dump_idx,
  output logic        busy,
  output logic        done,
  output logic        wd_expired,
  output logic [15:0] run_cycles
);

  localparam logic [4:0] LastIdx = 5'(DUMP_WORDS - 1);

  run_state_e  state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [4:0]  dump_idx_q, dump_idx_d;
  logic        wd_expired_q, wd_expired_d;
  logic [15:0] run_cycles_q, run_cycles_d;

  logic        mon_clr, mon_en, mon_stop, mon_wd_hit;
  logic [31:0] mon_count;

  assign mon_clr = (state_q == StHold);
  assign mon_en  = (state_q == StRun);

  mips_run_monitor #(
    .NOP_TIMEOUT(NOP_TIMEOUT),
    .WATCHDOG   (WATCHDOG)
  ) u_monitor (
    .clk   (clk),
    .rst   (rst),
    .clr   (mon_clr),
    .en    (mon_en),
    .inst  (inst),
    .stop  (mon_stop),
    .wd_hit(mon_wd_hit),
    .count (mon_count)
  );

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    dump_idx_d   = dump_idx_q;
    wd_expired_d = wd_expired_q;
    run_cycles_d = run_cycles_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StHold;
          hold_d       = '0;
          dump_idx_d   = '0;
          wd_expired_d = 1'b0;
          run_cycles_d = '0;
        end
      end
      StHold: begin
        wd_expired_d = 1'b0;
        run_cycles_d = '0;
        if (hold_q == RESET_CYCLES - 1) begin
          state_d = StRun;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      StRun: begin
        if (mon_stop) begin
          state_d      = StDump;
          wd_expired_d = mon_wd_hit;
          run_cycles_d = sat16(mon_count);
          dump_idx_d   = '0;
        end
      end
      StDump: begin
        if (dump_ready) begin
          if (dump_idx_q == LastIdx) begin
            state_d    = StDone;
            dump_idx_d = '0;
          end else begin
            dump_idx_d = dump_idx_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      dump_idx_q   <= '0;
      wd_expired_q <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      dump_idx_q   <= dump_idx_d;
      wd_expired_q <= wd_expired_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Memory port mux: the core owns the port in RUN, the dump streamer in DUMP.
  always_comb begin
    mem_addr      = '0;
    mem_wr        = 1'b0;
    mem_wdata     = '0;
    core_data_out = '0;
    dump_valid    = 1'b0;
    dump_data     = '0;
    if (state_q == StRun) begin
      mem_addr      = core_data_addr;
      mem_wr        = core_data_wr;
      mem_wdata     = core_data_in;
      core_data_out = mem_rdata;
    end else if (state_q == StDump) begin
      mem_addr   = {25'd0, dump_idx_q, 2'b00};
      dump_valid = 1'b1;
      dump_data  = mem_rdata;
    end
  end

  assign core_rst_n = (state_q == StRun);
  assign busy       = (state_q == StHold) || (state_q == StRun) || (state_q == StDump);
  assign done       = (state_q == StDone);
  assign dump_idx   = dump_idx_q;
  assign wd_expired = wd_expired_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;

  localparam int ResetCycles = 10;
  localparam int DumpWords   = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, core_data_wr, mem_wr, core_rst_n;
  logic [31:0] inst, core_data_addr, core_data_in, core_data_out;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dump_data;
  logic        dump_valid, dump_ready, busy, done, wd_expired;
  logic [4:0]  dump_idx;
  logic [15:0] run_cycles;

  // Second instance: watchdog equal to the nop limit.
  logic        b_start, b_mem_wr, b_core_rst_n, b_dump_valid, b_busy, b_done, b_wd_expired;
  logic [31:0] b_core_data_out, b_mem_addr, b_mem_wdata, b_dump_data;
  logic [4:0]  b_dump_idx;
  logic [15:0] b_run_cycles;

  mips_run_ctrl #(
    .RESET_CYCLES(10), .NOP_TIMEOUT(9), .WATCHDOG(500), .DUMP_WORDS(22)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .inst(inst),
    .core_data_addr(core_data_addr), .core_data_wr(core_data_wr),
    .core_data_in(core_data_in), .core_data_out(core_data_out), .core_rst_n(core_rst_n),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .busy(busy), .done(done), .wd_expired(wd_expired),
    .run_cycles(run_cycles)
  );

  mips_run_ctrl #(
    .RESET_CYCLES(10), .NOP_TIMEOUT(9), .WATCHDOG(9), .DUMP_WORDS(22)
  ) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .inst(32'd0),
    .core_data_addr(32'd0), .core_data_wr(1'b0),
    .core_data_in(32'd0), .core_data_out(b_core_data_out), .core_rst_n(b_core_rst_n),
    .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata), .mem_rdata(32'd0),
    .dump_valid(b_dump_valid), .dump_ready(1'b1), .dump_data(b_dump_data),
    .dump_idx(b_dump_idx), .busy(b_busy), .done(b_done), .wd_expired(b_wd_expired),
    .run_cycles(b_run_cycles)
  );

  // Data memory: combinational read, synchronous write, bulk preload.
  logic [31:0] mem [0:63];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (mem_wr) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  logic [31:0] exp_mem [0:63];

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } xfer_t;
  xfer_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic hold_phase(input string tag);
    int n = 0;
    int bad_busy = 0;
    while (core_rst_n == 1'b0 && n < 50) begin
      if (busy !== 1'b1) bad_busy++;
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_hold_len"}, 32'(n), 32'(ResetCycles));
    check_eq({tag, "_hold_busy"}, 32'(bad_busy), 32'd0);
  endtask

  // Drives one instruction per RUN cycle; first nz are nonzero, then zeros.
  task automatic run_phase(input int nz, input bit do_wr, input bit poke_start, output int n);
    n = 0;
    while (core_rst_n == 1'b1 && n < 1000) begin
      inst = (n < nz) ? 32'h2400_0001 + 32'(n) : 32'd0;
      if (do_wr && n == 4) begin
        core_data_addr = 32'd12;
        core_data_in   = 32'h1234_5678;
        core_data_wr   = 1'b1;
        exp_mem[3]     = 32'h1234_5678;
        #1;
        check_eq("run_mux_wr", {31'd0, mem_wr}, 32'd1);
        check_eq("run_mux_addr", mem_addr, 32'd12);
      end
      if (do_wr && n == 5) core_data_wr = 1'b0;
      if (do_wr && n == 7) check_eq("run_rdata", core_data_out, 32'h1234_5678);
      if (poke_start) start = (n == 20);
      n++;
      @(negedge clk);
    end
    inst = 32'd0;
    start = 1'b0;
    core_data_wr = 1'b0;
  endtask

  task automatic push_expected();
    sb_q.delete();
    for (int i = 0; i < DumpWords; i++) sb_q.push_back({5'(i), exp_mem[i]});
  endtask

  task automatic dump_phase(input bit toggle, output int xfers);
    int    g = 0;
    bit    stalled = 0;
    logic [31:0] pd;
    logic [4:0]  pi;
    xfer_t e;
    xfers = 0;
    while (dump_valid == 1'b1 && g < 200) begin
      if (stalled) begin
        check_eq("stall_data", dump_data, pd);
        check_eq("stall_idx", {27'd0, dump_idx}, {27'd0, pi});
      end
      if (mem_wr !== 1'b0) check_eq("dump_mem_wr", {31'd0, mem_wr}, 32'd0);
      dump_ready = toggle ? (g % 2 == 0) : 1'b1;
      if (dump_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("dump_idx", {27'd0, dump_idx}, {27'd0, e.idx});
          check_eq("dump_data", dump_data, e.data);
        end
        xfers++;
        stalled = 0;
      end else begin
        pd = dump_data;
        pi = dump_idx;
        stalled = 1;
      end
      g++;
      @(negedge clk);
    end
    dump_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, dump_valid}, 32'd0);
    check_eq({tag, "_idx"}, {27'd0, dump_idx}, 32'd0);
    check_eq({tag, "_rstn"}, {31'd0, core_rst_n}, 32'd0);
    check_eq({tag, "_wd"}, {31'd0, wd_expired}, 32'd0);
    check_eq({tag, "_runcyc"}, {16'd0, run_cycles}, 32'd0);
    check_eq({tag, "_cdout"}, core_data_out, 32'd0);
  endtask

  initial begin
    int n, x, g;
    rst = 1'b1; preload = 1'b1; start = 1'b0; b_start = 1'b0; inst = 32'd0;
    core_data_addr = 32'd0; core_data_wr = 1'b0; core_data_in = 32'd0; dump_ready = 1'b0;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'hA000_0000 + 32'(i);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    start = 1'b1;  // ignored while rst is high
    @(negedge clk);
    start = 1'b0;
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_after_rst_busy", {31'd0, busy}, 32'd0);

    // Run 1: 30 nonzero instructions, then zeros; toggling dump_ready.
    do_start();
    hold_phase("run1");
    run_phase(30, 1'b1, 1'b0, n);
    check_eq("run1_cycles_seen", 32'(n), 32'd39);
    check_eq("run1_run_cycles", {16'd0, run_cycles}, 32'd39);
    check_eq("run1_wd", {31'd0, wd_expired}, 32'd0);
    check_eq("run1_dump_valid", {31'd0, dump_valid}, 32'd1);
    check_eq("run1_busy", {31'd0, busy}, 32'd1);
    core_data_wr = 1'b1;  // must not reach memory outside RUN
    core_data_addr = 32'd0;
    core_data_in = 32'hDEAD_BEEF;
    push_expected();
    dump_phase(1'b1, x);
    core_data_wr = 1'b0;
    check_eq("run1_xfers", 32'(x), 32'(DumpWords));
    check_eq("run1_done", {31'd0, done}, 32'd1);
    check_eq("run1_busy_end", {31'd0, busy}, 32'd0);
    check_eq("run1_idx_wrap", {27'd0, dump_idx}, 32'd0);
    check_eq("run1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Run 2: never idle -> watchdog; start poked mid-run; reset mid-dump at idx 5.
    do_start();
    check_eq("run2_done_clr", {31'd0, done}, 32'd0);
    check_eq("run2_runcyc_clr", {16'd0, run_cycles}, 32'd0);
    hold_phase("run2");
    run_phase(100000, 1'b0, 1'b1, n);
    check_eq("run2_cycles_seen", 32'(n), 32'd500);
    check_eq("run2_run_cycles", {16'd0, run_cycles}, 32'd500);
    check_eq("run2_wd", {31'd0, wd_expired}, 32'd1);
    dump_ready = 1'b1;
    g = 0;
    while (dump_idx != 5'd5 && g < 50) begin
      g++;
      @(negedge clk);
    end
    check_eq("run2_at_idx5", {27'd0, dump_idx}, 32'd5);
    check_eq("run2_valid_idx5", {31'd0, dump_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    dump_ready = 1'b0;
    check_idle("middump_rst");
    rst = 1'b0;
    @(negedge clk);

    // Run 3: all zeros from clean counters -> nop exit after 9 cycles.
    do_start();
    hold_phase("run3");
    run_phase(0, 1'b0, 1'b0, n);
    check_eq("run3_cycles_seen", 32'(n), 32'd9);
    check_eq("run3_run_cycles", {16'd0, run_cycles}, 32'd9);
    check_eq("run3_wd", {31'd0, wd_expired}, 32'd0);
    push_expected();
    dump_phase(1'b0, x);
    check_eq("run3_xfers", 32'(x), 32'(DumpWords));
    check_eq("run3_done", {31'd0, done}, 32'd1);

    // Instance B: nop and watchdog limits hit together -> wd_expired stays 0.
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    g = 0;
    while (b_core_rst_n == 1'b0 && g < 50) begin
      g++;
      @(negedge clk);
    end
    check_eq("b_hold_len", 32'(g), 32'(ResetCycles));
    n = 0;
    while (b_core_rst_n == 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("b_cycles_seen", 32'(n), 32'd9);
    check_eq("b_run_cycles", {16'd0, b_run_cycles}, 32'd9);
    check_eq("b_wd", {31'd0, b_wd_expired}, 32'd0);
    check_eq("b_dump_valid", {31'd0, b_dump_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
